fifo_reader: RTL and testbench

Read-side controller for the `fifo` queue. It drains words from the queue and presents them to a downstream consumer over a valid/ready handshake. The queue has no empty flag, and its `out` register lags its read pointer by one cycle. To work with that, the block keeps a shadow occupancy count by snooping the writer's `push`, and it issues `pop` pulses only when the queue's `out` is guaranteed to show the head word. It sits between the queue and any consumer, and is instantiated with the same `N`/`M`.

---
 rtl/fifo_reader_if.sv | 35 +++
 rtl/fifo_reader.sv | 126 ++++++++++++
 tb/tb_fifo_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_reader_if
//   Valid/ready handshake between fifo_reader and its downstream consumer.
//
//   Parameters
//     M         word width carried on rd_data
//
//   Signals
//     rd_valid  reader -> consumer  rd_data holds an undelivered word
//     rd_ready  consumer -> reader  consumer accepts the word this cycle
//     rd_data   reader -> consumer  delivered word
//
//   Modports
//     master    the reader side (drives rd_valid/rd_data)
//     slave     the consumer side (drives rd_ready)
// -----------------------------------------------------------------------------
interface fifo_reader_if #(
  parameter int unsigned M = 2
);
  logic         rd_valid;
  logic         rd_ready;
  logic [M-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//   Read-side controller for the fifo queue. The queue has no empty flag and
//   its out register lags the read pointer by one cycle, so this block keeps a
//   shadow occupancy count by snooping the writer's push and only pops when
//   the queue's out is known to already show the head word. Popped words are
//   offered to a consumer over a valid/ready handshake.
//
//   Parameters
//     N          queue depth (must match the paired queue)
//     M          word width  (must match the paired queue)
//
//   Ports
//     clk        single clock, shared with the queue
//     reset      asynchronous, active-low reset
//     flush      synchronous, active-high clear (the queue's own reset)
//     fifo_push  copy of the writer's push into the queue
//     fifo_out   queue out port
//     fifo_pop   queue pop port (high only in SETTLE)
//     rd         consumer handshake (rd_valid / rd_ready / rd_data)
//     level      shadow occupancy, 0..N
//     empty      level == 0
//     drop_err   sticky: a push was dropped by the full queue
// -----------------------------------------------------------------------------
module fifo_reader #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 fifo_push,
  input  logic [M-1:0]         fifo_out,
  output logic                 fifo_pop,
  fifo_reader_if.master        rd,
  output logic [$clog2(N):0]   level,
  output logic                 empty,
  output logic                 drop_err
);

  localparam int unsigned LW = $clog2(N) + 1;

  typedef logic [LW-1:0] lvl_t;

  localparam lvl_t LVL_FULL = lvl_t'(N);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    VALID
  } state_t;

  state_t       state_q;
  state_t       state_d;
  lvl_t         lvl_q;
  lvl_t         lvl_d;
  logic         acc;
  logic         drop;
  logic         rd_valid_q;
  logic         rd_valid_d;
  logic [M-1:0] rd_data_q;
  logic         drop_err_q;

  // Pop is a pure state decode: no combinational path from rd_ready or push.
  assign fifo_pop = (state_q == SETTLE);

  // A push is taken by the queue unless it is full and not popping this cycle.
  assign acc  = fifo_push && ((lvl_q < LVL_FULL) || fifo_pop);
  assign drop = fifo_push && (lvl_q == LVL_FULL) && !fifo_pop;

  always_comb begin
    lvl_d = lvl_q + lvl_t'(acc) - lvl_t'(fifo_pop);
  end

  // Leaving IDLE/VALID towards SETTLE looks at the registered count only:
  // a non-zero registered count means the head word was already in the
  // queue on the previous edge, so fifo_out shows it during SETTLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lvl_q != '0) state_d = SETTLE;
      end
      SETTLE: begin
        state_d = VALID;
      end
      VALID: begin
        if (rd.rd_ready) state_d = (lvl_q != '0) ? SETTLE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_valid_d = (state_d == VALID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_err_q <= 1'b0;
    end else if (flush) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      rd_valid_q <= rd_valid_d;
      if (state_q == SETTLE) rd_data_q <= fifo_out;
      if (drop) drop_err_q <= 1'b1;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign level       = lvl_q;
  assign empty       = (lvl_q == '0);
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  localparam int unsigned N = 4;
  localparam int unsigned M = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              fifo_push;
  logic [M-1:0]      push_data;
  logic [M-1:0]      fifo_out;
  logic              fifo_pop;
  logic [$clog2(N):0] level;
  logic              empty;
  logic              drop_err;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_reader_if #(.M(M)) rd_if ();

  fifo_reader #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fifo_push (fifo_push),
    .fifo_out  (fifo_out),
    .fifo_pop  (fifo_pop),
    .rd        (rd_if),
    .level     (level),
    .empty     (empty),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the paired queue: out is registered from the
  // read pointer, so it shows the head word one cycle after it is written.
  logic [M-1:0] mem [N];
  logic [1:0]   wp;
  logic [1:0]   rp;
  int           cnt;

  always @(posedge clk) begin
    if (flush) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= 0;
      fifo_out <= '0;
    end else begin
      fifo_out <= mem[rp];
      if (fifo_pop) rp <= rp + 2'd1;
      if (fifo_push && (cnt < int'(N) || fifo_pop)) begin
        mem[wp] <= push_data;
        wp      <= wp + 2'd1;
      end
      cnt <= cnt + ((fifo_push && (cnt < int'(N) || fifo_pop)) ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [M-1:0] d);
    fifo_push = 1'b1;
    push_data = d;
    step();
    fifo_push = 1'b0;
  endtask

  logic [M-1:0] ov_exp [5];
  logic [M-1:0] fs_exp [5];

  initial begin
    ov_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    fs_exp = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    reset          = 1'b0;
    flush          = 1'b1;
    fifo_push      = 1'b0;
    push_data      = '0;
    rd_if.rd_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_valid", rd_if.rd_valid, 0);
    check("rst_pop", fifo_pop, 0);
    check("rst_drop", drop_err, 0);
    check("rst_data", rd_if.rd_data, 0);
    flush = 1'b0;
    reset = 1'b1;
    step();

    // Single word, first-word latency
    rd_if.rd_ready = 1'b1;
    push_word(2'b10);
    check("sw_e1_level", level, 1);
    check("sw_e1_pop", fifo_pop, 0);
    check("sw_e1_empty", empty, 0);
    step();
    check("sw_e2_pop", fifo_pop, 1);
    check("sw_e2_valid", rd_if.rd_valid, 0);
    step();
    check("sw_e3_valid", rd_if.rd_valid, 1);
    check("sw_e3_data", rd_if.rd_data, 2'b10);
    check("sw_e3_level", level, 0);
    check("sw_e3_pop", fifo_pop, 0);
    step();
    check("sw_e4_valid", rd_if.rd_valid, 0);
    check("sw_e4_pop", fifo_pop, 0);

    // Overflow: one word sits in rd_data, four fill the queue, next is dropped
    rd_if.rd_ready = 1'b0;
    push_word(2'd1);
    push_word(2'd2);
    push_word(2'd3);
    push_word(2'd0);
    push_word(2'd1);
    check("ov_level_full", level, 4);
    check("ov_drop_before", drop_err, 0);
    push_word(2'd3);
    check("ov_drop", drop_err, 1);
    check("ov_level_held", level, 4);
    rd_if.rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("ov_valid", rd_if.rd_valid, 1);
      check("ov_data", rd_if.rd_data, ov_exp[k]);
      step();
      check("ov_gap", rd_if.rd_valid, 0);
      step();
    end
    check("ov_drop_sticky", drop_err, 1);
    check("ov_level_end", level, 0);
    check("ov_empty_end", empty, 1);

    // Flush in VALID with level 3
    rd_if.rd_ready = 1'b0;
    push_word(2'd0);
    push_word(2'd1);
    push_word(2'd2);
    push_word(2'd3);
    check("fl_level_pre", level, 3);
    check("fl_valid_pre", rd_if.rd_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", rd_if.rd_valid, 0);
    check("fl_level", level, 0);
    check("fl_drop", drop_err, 0);
    check("fl_data", rd_if.rd_data, 0);
    check("fl_pop", fifo_pop, 0);
    rd_if.rd_ready = 1'b1;
    push_word(2'd1);
    check("fl_e1_level", level, 1);
    step();
    check("fl_e2_pop", fifo_pop, 1);
    step();
    check("fl_e3_valid", rd_if.rd_valid, 1);
    check("fl_e3_data", rd_if.rd_data, 1);
    step();
    check("fl_e4_valid", rd_if.rd_valid, 0);

    // Backpressure in VALID with level 2
    rd_if.rd_ready = 1'b0;
    push_word(2'd3);
    push_word(2'd2);
    push_word(2'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rd_if.rd_valid, 1);
      check("bp_data", rd_if.rd_data, 3);
      check("bp_pop", fifo_pop, 0);
      check("bp_level", level, 2);
      step();
    end
    rd_if.rd_ready = 1'b1;
    step();
    check("bp_settle_pop", fifo_pop, 1);
    step();
    check("bp_data2", rd_if.rd_data, 2);
    step();
    step();
    check("bp_data3", rd_if.rd_data, 1);
    check("bp_level_end", level, 0);
    step();
    check("bp_idle", rd_if.rd_valid, 0);

    // Full queue with push during SETTLE: net occupancy unchanged, no drop
    rd_if.rd_ready = 1'b0;
    push_word(2'd1);
    push_word(2'd2);
    push_word(2'd3);
    push_word(2'd0);
    push_word(2'd1);
    check("fs_level_full", level, 4);
    rd_if.rd_ready = 1'b1;
    step();
    rd_if.rd_ready = 1'b0;
    check("fs_settle_pop", fifo_pop, 1);
    check("fs_settle_level", level, 4);
    push_word(2'd2);
    check("fs_level", level, 4);
    check("fs_drop", drop_err, 0);
    rd_if.rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("fs_valid", rd_if.rd_valid, 1);
      check("fs_data", rd_if.rd_data, fs_exp[k]);
      step();
      step();
    end
    check("fs_level_end", level, 0);
    check("fs_drop_end", drop_err, 0);

    // Asynchronous reset while VALID
    rd_if.rd_ready = 1'b0;
    push_word(2'd2);
    step();
    step();
    check("ar_valid_pre", rd_if.rd_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", rd_if.rd_valid, 0);
    check("ar_pop", fifo_pop, 0);
    check("ar_level", level, 0);
    check("ar_empty", empty, 1);
    check("ar_data", rd_if.rd_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ar_no_pop", fifo_pop, 0);
      check("ar_no_valid", rd_if.rd_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
